// File: rtl/can_tx_pkg.sv
// Shared types and constants for the CAN transmit scheduler.
package can_tx_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SELECT = 2'd1,
    START  = 2'd2,
    WAIT   = 2'd3
  } tx_state_t;

  localparam int CAN_ID_W = 11;  // standard CAN identifier
  localparam int RETRY_W  = 8;

endpackage

// File: rtl/can_prio_enc.sv
// Minimum-identifier finder; ties resolve to the lowest buffer index.
module can_prio_enc
  import can_tx_pkg::*;
#(
  parameter int NBUF = 4,
  parameter int ID_W = CAN_ID_W
) (
  input  logic [NBUF-1:0]         elig,
  input  logic [NBUF*ID_W-1:0]    buf_id,
  output logic                    valid,
  output logic [$clog2(NBUF)-1:0] idx
);

  localparam int SEL_W = $clog2(NBUF);

  logic [ID_W-1:0] best_id;

  always_comb begin
    valid   = 1'b0;
    idx     = '0;
    best_id = '0;
    for (int i = 0; i < NBUF; i++) begin
      // strict less-than keeps the earlier index on equal identifiers
      if (elig[i] && (!valid || (buf_id[i*ID_W +: ID_W] < best_id))) begin
        valid   = 1'b1;
        idx     = SEL_W'(i);
        best_id = buf_id[i*ID_W +: ID_W];
      end
    end
  end

endmodule

// File: rtl/can_tx_sched.sv
// CAN transmit scheduler: lowest-ID arbitration, start/outcome sequencing, abort.
// Optional retry limit via CAN_TX_RETRY_LIMIT_EN (otherwise unlimited retransmission).
module can_tx_sched
  import can_tx_pkg::*;
#(
  parameter int NBUF      = 4,
  parameter int ID_W      = CAN_ID_W,
  parameter int RETRY_MAX = 8
) (
  input  logic                    clk,
  input  logic                    g_rst,
  input  logic [NBUF-1:0]         buf_req,
  input  logic [NBUF*ID_W-1:0]    buf_id,
  input  logic [NBUF-1:0]         buf_abort,
  input  logic                    fg_ready,
  input  logic                    tx_success,
  input  logic                    tx_arb_lost,
  input  logic                    tx_error,
  output logic                    tx_start,
  output logic [$clog2(NBUF)-1:0] tx_sel,
  output logic                    tx_busy,
  output logic [NBUF-1:0]         tx_done,
  output logic [NBUF-1:0]         tx_abort_ack,
  output logic [NBUF-1:0]         tx_fail
);

  localparam int SEL_W = $clog2(NBUF);

  if (NBUF < 2 || NBUF > 16 || RETRY_MAX < 1) begin : g_bad_param
    $error("can_tx_sched: NBUF must be 2..16 and RETRY_MAX at least 1");
  end

  tx_state_t        state, state_n;
  logic [SEL_W-1:0] sel_q;
  logic [RETRY_W-1:0] retry_cnt, retry_n;
  logic [NBUF-1:0]  abort_pend, abort_pend_n;
  logic [NBUF-1:0]  done_n, ack_n, fail_n;
  logic [NBUF-1:0]  sel_oh, inflight, elig, excl;
  logic             enc_valid;
  logic [SEL_W-1:0] enc_idx;

  assign sel_oh   = NBUF'(1) << sel_q;
  assign inflight = (state == WAIT) ? sel_oh : '0;
  assign tx_sel   = sel_q;
  assign tx_busy  = (state != IDLE);

  // buffers whose completion is being reported this cycle must not be re-picked
  assign elig = buf_req & ~abort_pend & ~excl & ~(tx_done | tx_abort_ack | tx_fail);

  can_prio_enc #(.NBUF(NBUF), .ID_W(ID_W)) u_prio (
    .elig   (elig),
    .buf_id (buf_id),
    .valid  (enc_valid),
    .idx    (enc_idx)
  );

  always_comb begin
    state_n      = state;
    retry_n      = retry_cnt;
    done_n       = '0;
    fail_n       = '0;
    ack_n        = buf_abort & ~inflight;
    // the in-flight buffer keeps its pending abort even if its request drops
    abort_pend_n = (abort_pend | buf_abort) & (buf_req | inflight);
    tx_start     = 1'b0;
    case (state)
      IDLE: if (|elig) state_n = SELECT;
      SELECT: begin
        if (enc_valid) begin
          state_n = START;
          if (enc_idx != sel_q) retry_n = '0;
        end else begin
          state_n = IDLE;
        end
      end
      START: begin
        if (!buf_req[sel_q] || abort_pend[sel_q] || buf_abort[sel_q]) begin
          state_n = IDLE;
        end else if (fg_ready) begin
          tx_start = 1'b1;
          state_n  = WAIT;
        end
      end
      WAIT: begin
        if (tx_success) begin
          done_n  = sel_oh;
          retry_n = '0;
          state_n = IDLE;
        end else if (tx_arb_lost || tx_error) begin
          state_n = IDLE;
          if (abort_pend[sel_q] || buf_abort[sel_q]) begin
            ack_n = ack_n | sel_oh;
`ifdef CAN_TX_RETRY_LIMIT_EN
          end else if (retry_cnt == RETRY_W'(RETRY_MAX - 1)) begin
            fail_n  = sel_oh;
            retry_n = '0;
`endif
          end else if (retry_cnt != '1) begin
            retry_n = retry_cnt + RETRY_W'(1);
          end
        end
      end
      default: state_n = IDLE;
    endcase
    if (|(ack_n & sel_oh)) retry_n = '0;
  end

  always_ff @(posedge clk or posedge g_rst) begin
    if (g_rst) begin
      state        <= IDLE;
      sel_q        <= '0;
      retry_cnt    <= '0;
      abort_pend   <= '0;
      tx_done      <= '0;
      tx_abort_ack <= '0;
    end else begin
      state        <= state_n;
      retry_cnt    <= retry_n;
      abort_pend   <= abort_pend_n;
      tx_done      <= done_n;
      tx_abort_ack <= ack_n;
      if (state == SELECT && enc_valid) sel_q <= enc_idx;
    end
  end

`ifdef CAN_TX_RETRY_LIMIT_EN
  logic [NBUF-1:0] fail_excl;

  always_ff @(posedge clk or posedge g_rst) begin
    if (g_rst) begin
      fail_excl <= '0;
      tx_fail   <= '0;
    end else begin
      fail_excl <= (fail_excl | fail_n) & buf_req;
      tx_fail   <= fail_n;
    end
  end

  assign excl = fail_excl;
`else
  assign excl    = '0;
  assign tx_fail = '0;
`endif

endmodule
